// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared constants and FSM state encoding for the IM loader
package im_loader_pkg;

  localparam int IM_ADDR_W  = 10;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/im_byte_packer.sv
// rtl/im_byte_packer.sv - shifts stream bytes into a big-endian 32-bit word
module im_byte_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_accept,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  // Byte k lands in lane 3-k; for a 2-bit index that lane is simply ~k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_idx  <= '0;
    end else if (i_accept) begin
      r_word[{~r_idx, 3'b000} +: 8] <= i_data;
      r_idx                         <= r_idx + 2'd1;
    end
  end

  assign o_word       = r_word;
  assign o_word_ready = i_accept && (r_idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - loads a byte-streamed program into instruction memory
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  len,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [CNT_W-1:0]  words_written
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_words;
  logic              w_start_acc;
  logic              w_accept;
  logic              w_word_ready;
  logic              w_last;
  logic [31:0]       w_word;

  assign w_start_acc = start && (r_state == ST_IDLE);
  assign w_accept    = in_valid && (r_state == ST_RECV);
  assign w_last      = (r_words + CNT_W'(1)) == r_len;

  im_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_start_acc),
    .i_accept     (w_accept),
    .i_data       (in_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (len != '0) ? ST_RECV : ST_DONE;
      ST_RECV:  if (w_word_ready) w_next = ST_WRITE;
      ST_WRITE: w_next = w_last ? ST_DONE : ST_RECV;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // All handshake/status outputs are pure state decodes.
  always_comb begin
    in_ready = (r_state == ST_RECV);
    im_we    = (r_state == ST_WRITE);
    busy     = (r_state == ST_RECV) || (r_state == ST_WRITE);
    done     = (r_state == ST_DONE);
    cpu_hold = busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base  <= '0;
      r_len   <= '0;
      r_words <= '0;
    end else if (w_start_acc) begin
      r_base  <= base_addr;
      r_len   <= len;
      r_words <= '0;
    end else if (r_state == ST_WRITE) begin
      r_words <= r_words + CNT_W'(1);
    end
  end

  // Address arithmetic wraps naturally at the top of the IM.
  assign im_addr       = r_base + r_words[ADDR_W-1:0];
  assign im_wdata      = w_word;
  assign words_written = r_words;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed self-checking bench for im_loader
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] len = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, im_we, busy, done, cpu_hold;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] words_written;

  im_loader #(.ADDR_W(10), .CNT_W(11)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .len           (len),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .im_we         (im_we),
    .im_addr       (im_addr),
    .im_wdata      (im_wdata),
    .busy          (busy),
    .done          (done),
    .cpu_hold      (cpu_hold),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] tb_mem [0:1023];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          bad_ready = 0;

  // IM model and event counters, sampled on the falling edge
  always @(negedge clk) begin
    if (im_we) begin
      tb_mem[im_addr] = im_wdata;
      wr_cnt++;
      if (in_ready) bad_ready++;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] b, input logic [10:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", n, 0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int k = 0; k < 4; k++)
      send_byte(w[31-8*k -: 8], rnd ? int'($urandom_range(0, 5)) : 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
    tick();
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [9:0] a;
    a = 10'(i);
    return {a[7:0], {a[9:8], a[5:0]}, 8'hC3, a[7:0] ^ 8'h5A};
  endfunction

  int w0, d0, b0, r0;

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_ctl", {in_ready, im_we, busy, done, cpu_hold}, 0);
    check("reset_addr", im_addr, 0);
    check("reset_wdata", im_wdata, 0);
    check("reset_words", words_written, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // back-to-back two-word load from address 0
    w0 = wr_cnt; d0 = done_cnt;
    do_start(10'd0, 11'd2);
    check("t1_busy", {busy, cpu_hold, in_ready}, 3'b111);
    send_word(32'h341d000c, 1'b0);
    send_word(32'h34021234, 1'b0);
    wait_done();
    check("t1_mem0", tb_mem[0], 32'h341d000c);
    check("t1_mem1", tb_mem[1], 32'h34021234);
    check("t1_writes", wr_cnt - w0, 2);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_words", words_written, 2);
    check("t1_hold_off", cpu_hold, 0);

    // zero-length load
    w0 = wr_cnt; b0 = busy_cnt;
    do_start(10'd7, 11'd0);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    tick();
    check("t2_done_off", done, 0);
    check("t2_busy_cnt", busy_cnt - b0, 0);
    check("t2_writes", wr_cnt - w0, 0);
    check("t2_words", words_written, 0);

    // address wrap at the top of the IM
    do_start(10'd1023, 11'd2);
    send_word(32'hcafebabe, 1'b0);
    send_word(32'h12345678, 1'b1);
    wait_done();
    check("t3_mem1023", tb_mem[1023], 32'hcafebabe);
    check("t3_mem0", tb_mem[0], 32'h12345678);
    check("t3_addr_after", im_addr, 1);

    // full 1024-word load with random valid gaps
    w0 = wr_cnt; r0 = bad_ready;
    do_start(10'd0, 11'd1024);
    for (int i = 0; i < 1024; i++) send_word(pat(i), 1'b1);
    wait_done();
    for (int i = 0; i < 1024; i++) check("t4_mem", tb_mem[i], pat(i));
    check("t4_writes", wr_cnt - w0, 1024);
    check("t4_ready_in_write", bad_ready - r0, 0);
    check("t4_words", words_written, 1024);

    // start pulses during RECV and WRITE are ignored
    w0 = wr_cnt;
    do_start(10'd100, 11'd2);
    send_byte(8'haa, 0);
    send_byte(8'hbb, 0);
    do_start(10'd200, 11'd1);
    send_byte(8'hcc, 0);
    send_byte(8'hdd, 0);
    do_start(10'd300, 11'd3);
    send_word(32'h01020304, 1'b0);
    wait_done();
    check("t5_mem100", tb_mem[100], 32'haabbccdd);
    check("t5_mem101", tb_mem[101], 32'h01020304);
    check("t5_writes", wr_cnt - w0, 2);
    check("t5_words", words_written, 2);

    // asynchronous reset in the middle of the third word
    w0 = wr_cnt;
    do_start(10'd10, 11'd4);
    send_word(32'ha0a1a2a3, 1'b0);
    send_word(32'hb0b1b2b3, 1'b0);
    send_byte(8'hc0, 0);
    send_byte(8'hc1, 0);
    rst = 1'b1;
    #1;
    check("t6_ctl", {in_ready, im_we, busy, done, cpu_hold}, 0);
    check("t6_addr", im_addr, 0);
    check("t6_wdata", im_wdata, 0);
    check("t6_words", words_written, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_writes", wr_cnt - w0, 2);
    check("t6_mem10", tb_mem[10], 32'ha0a1a2a3);
    check("t6_mem11", tb_mem[11], 32'hb0b1b2b3);
    do_start(10'd5, 11'd1);
    send_word(32'h11223344, 1'b0);
    wait_done();
    check("t6_mem5", tb_mem[5], 32'h11223344);
    check("t6_words_after", words_written, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
